uart_echo_buffered: RTL and testbench
=====================================

// Module: uart_echo_buffered
// PURPOSE
//  UART loopback with an RX->TX FIFO. Each received frame is buffered and retransmitted unchanged.
//  Adds: parametrised width and depth, TX flow-control hold, sticky error flags, optional parity.
//  Sits between the board pins (or top-level PLL clock domain) and the host serial link.
// PARAMETERS
//  DataWidth  8      data bits per frame, 5..9, sent LSB first
//  Prescale   16'd1  clk_i cycles per oversample tick; bit period = Prescale*8 cycles
//  Depth      16     FIFO entries, power of two >= 2
//  StopBits   1      stop bits, 1 or 2; applies to TX and RX
//  ParityOdd  1'b0   0 = even, 1 = odd; used only when UART_ECHO_PARITY_EN is defined
// PORTS
//  clk_i         in   1                  single clock
//  reset_i       in   1                  asynchronous, active-high reset
//  rx_data_i     in   1                  serial in, idle high
//  tx_data_o     out  1                  serial out, idle high
//  tx_hold_i     in   1                  1 = do not start a new TX frame
//  clear_err_i   in   1                  1 for one cycle clears all sticky flags
//  fifo_count_o  out  $clog2(Depth)+1    current FIFO occupancy
//  overflow_o    out  1                  sticky: a valid byte was dropped because the FIFO was full
//  frame_err_o   out  1                  sticky: a stop bit was sampled low
//  parity_err_o  out  1                  sticky: parity mismatch
// BEHAVIOUR
//  Reset values: tx_data_o=1, fifo_count_o=0, all flags 0, FIFO emptied, both FSMs IDLE.
//  Reset is asynchronous. Asserting it mid-frame aborts the frame and drives tx_data_o=1 immediately.
//  RX path
//   - rx_data_i passes through a 2-flop synchroniser, reset value 1.
//   - RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE->START on a sampled 1->0 edge.
//   - START re-samples after 4 ticks (mid-bit). If the line is high, the start is false and the FSM returns to IDLE.
//   - Each data, parity and stop bit is sampled once, 8 ticks after the previous sample.
//   - StopBits=2 samples two stop bits. Any stop bit low sets frame_err_o and drops the byte.
//  Push decision: made on the cycle after the last stop-bit sample.
//   - If a FIFO slot is free, the byte is pushed.
//   - If the FIFO is full and TX pops in the same cycle, the byte is pushed.
//   - Otherwise the byte is dropped and overflow_o is set.
//  TX path
//   - TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Each bit is held exactly Prescale*8 cycles.
//   - IDLE pops when the FIFO is not empty and tx_hold_i=0, and enters START on the next cycle.
//   - tx_hold_i rising mid-frame does not truncate the frame; it only blocks the next pop.
//  Latency: echo start bit begins <= 3 cycles after the push when TX is IDLE and not held.
//  FIFO
//   - Simultaneous push and pop leaves fifo_count_o unchanged.
//   - Read and write pointers wrap modulo Depth; the extra count bit distinguishes full from empty.
//  Flags
//   - clear_err_i clears all flags.
//   - If clear_err_i and a new error occur in the same cycle, the new error wins and the flag stays 1.
// CONFIGURATION
//  UART_ECHO_PARITY_EN defined:
//   - TX appends one parity bit after the data bits, computed per ParityOdd.
//   - RX samples and checks the parity bit. A mismatch sets parity_err_o and drops the byte.
//   - If the same frame has both a parity and a framing error, both flags set.
//  UART_ECHO_PARITY_EN undefined:
//   - No parity bit on either path.
//   - parity_err_o is tied to 0. The port remains present.
// STRUCTURE
//  uart_echo_pkg: rx_state_e and tx_state_e enums, localparam OversampleRate=8, localparam MidTick=4.
//  Sub-module sync_fifo: Depth x DataWidth storage, push/pop/full/empty/count, asynchronous reset.
//  One shared tick generator (prescale counter) feeds both the RX and TX bit counters.
// TESTING  (Prescale=1, so bit period = 8 cycles)
//  1. Hold reset_i=1 for 2 cycles -> tx_data_o=1, fifo_count_o=0, all flags 0. Then assert reset mid-TX-frame -> tx_data_o=1 in the same cycle.
//  2. Send bytes 0x00..0xFF, one at a time -> each echoed frame is bit-identical (start/data/stop).
//  3. tx_hold_i=1, send 17 bytes 0x10..0x20 with Depth=16 -> fifo_count_o=16, overflow_o=1.
//     Then release tx_hold_i -> 0x10..0x1F echoed in order, 0x20 never appears.
//  4. Send 0x5A with the stop bit low -> frame_err_o=1, no echo, fifo_count_o=0.
//     Then pulse clear_err_i -> frame_err_o=0.
//  5. Drive rx_data_i low for 2 cycles, then high -> no push, tx_data_o stays 1, no flags set.
//  6. [UART_ECHO_PARITY_EN, ParityOdd=0]
//     - Send 0x07 with parity=1 -> echoed with parity=1.
//     - Send 0x07 with parity=0 -> parity_err_o=1, byte dropped.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the buffered UART echo (uart_echo_buffered).
package uart_echo_pkg;

  localparam int OversampleRate = 8;
  localparam int MidTick        = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Unused upper bits must be zero; odd=1 selects odd parity.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return odd ^ (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and occupancy count.
module sync_fifo #(
  parameter int DataWidth = 8,
  parameter int Depth     = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DataWidth-1:0]     wdata_i,
  output logic [DataWidth-1:0]     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AddrW = $clog2(Depth);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AddrW-1:0]     r_wr_ptr;
  logic [AddrW-1:0]     r_rd_ptr;
  logic [AddrW:0]       r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == (AddrW+1)'(Depth));
  assign w_do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign rdata_o   = r_mem[r_rd_ptr];
  assign count_o   = r_count;

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AddrW+1)'(1);
        2'b01:   r_count <= r_count - (AddrW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_buffered.sv
// UART loopback: received frames are queued in a FIFO and retransmitted unchanged.
// Define UART_ECHO_PARITY_EN to add a parity bit on both the RX and TX paths.
module uart_echo_buffered
  import uart_echo_pkg::*;
#(
  parameter int          DataWidth = 8,
  parameter logic [15:0] Prescale  = 16'd1,
  parameter int          Depth     = 16,
  parameter int          StopBits  = 1,
  parameter logic        ParityOdd = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    rx_data_i,
  output logic                    tx_data_o,
  input  logic                    tx_hold_i,
  input  logic                    clear_err_i,
  output logic [$clog2(Depth):0]  fifo_count_o,
  output logic                    overflow_o,
  output logic                    frame_err_o,
  output logic                    parity_err_o
);

`ifdef UART_ECHO_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam logic [2:0] MidLast  = 3'(MidTick - 1);
  localparam logic [2:0] BitLast  = 3'(OversampleRate - 1);
  localparam logic [3:0] DataLast = 4'(DataWidth - 1);
  localparam logic [3:0] StopLast = 4'(StopBits - 1);

  // Shared oversample tick
  logic [15:0] r_presc;
  logic        w_tick;
  assign w_tick = (r_presc == Prescale - 16'd1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 16'd1;
  end

  // RX path
  rx_state_e            r_rx_state, w_rx_next;
  logic [1:0]           r_rx_sync;
  logic                 r_rx_prev;
  logic [2:0]           r_rx_tcnt;
  logic [3:0]           r_rx_bidx;
  logic [DataWidth-1:0] r_rx_shift;
  logic                 r_rx_ferr, r_rx_perr, r_rx_done;
  logic                 w_rx, w_rx_sample, w_rx_last;

  assign w_rx        = r_rx_sync[1];
  assign w_rx_sample = w_tick &&
                       (r_rx_tcnt == ((r_rx_state == RX_START) ? MidLast : BitLast));

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_last = 1'b0;
    case (r_rx_state)
      RX_IDLE:   if (r_rx_prev && !w_rx) w_rx_next = RX_START;
      RX_START:  if (w_rx_sample) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_sample && r_rx_bidx == DataLast)
                   w_rx_next = ParityEn ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_sample) w_rx_next = RX_STOP;
      RX_STOP:   if (w_rx_sample && r_rx_bidx == StopLast) begin
                   w_rx_next = RX_IDLE;
                   w_rx_last = 1'b1;
                 end
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_rx_state <= RX_IDLE;
    else         r_rx_state <= w_rx_next;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rx_sync  <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_tcnt  <= '0;
      r_rx_bidx  <= '0;
      r_rx_shift <= '0;
      r_rx_ferr  <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], rx_data_i};
      r_rx_prev <= w_rx;
      r_rx_done <= w_rx_last;
      if (r_rx_state == RX_IDLE || w_rx_sample) r_rx_tcnt <= '0;
      else if (w_tick)                          r_rx_tcnt <= r_rx_tcnt + 3'd1;
      if (w_rx_sample) begin
        case (r_rx_state)
          RX_START: begin
            r_rx_bidx <= '0;
            r_rx_ferr <= 1'b0;
            r_rx_perr <= 1'b0;
          end
          RX_DATA: begin
            r_rx_shift <= {w_rx, r_rx_shift[DataWidth-1:1]};
            r_rx_bidx  <= (r_rx_bidx == DataLast) ? 4'd0 : r_rx_bidx + 4'd1;
          end
          RX_PARITY: r_rx_perr <= (w_rx != parity_bit(9'(r_rx_shift), ParityOdd));
          RX_STOP: begin
            if (!w_rx) r_rx_ferr <= 1'b1;
            r_rx_bidx <= r_rx_bidx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // FIFO and push decision, one cycle after the last stop-bit sample
  logic                 w_push, w_pop, w_full, w_empty;
  logic [DataWidth-1:0] w_rdata;

  assign w_push = r_rx_done && !r_rx_ferr && !r_rx_perr;

  sync_fifo #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (r_rx_shift),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (fifo_count_o)
  );

  // Sticky flags: a new error in the same cycle as clear keeps the flag set.
  logic r_ovf, r_ferr_flag, r_perr_flag;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ovf       <= 1'b0;
      r_ferr_flag <= 1'b0;
      r_perr_flag <= 1'b0;
    end else begin
      r_ovf       <= (w_push && w_full && !w_pop) | (r_ovf & ~clear_err_i);
      r_ferr_flag <= (r_rx_done && r_rx_ferr) | (r_ferr_flag & ~clear_err_i);
      r_perr_flag <= (r_rx_done && r_rx_perr) | (r_perr_flag & ~clear_err_i);
    end
  end

  assign overflow_o   = r_ovf;
  assign frame_err_o  = r_ferr_flag;
  assign parity_err_o = r_perr_flag;

  // TX path; pops only on a tick so every bit lasts exactly Prescale*8 cycles.
  tx_state_e            r_tx_state, w_tx_next;
  logic [2:0]           r_tx_tcnt;
  logic [3:0]           r_tx_bidx;
  logic [DataWidth-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 w_tx_bit_end, w_tx_out;

  assign w_tx_bit_end = w_tick && (r_tx_tcnt == BitLast);

  always_comb begin
    w_tx_next = r_tx_state;
    w_pop     = 1'b0;
    w_tx_out  = 1'b1;
    case (r_tx_state)
      TX_IDLE: if (w_tick && !w_empty && !tx_hold_i) begin
                 w_pop     = 1'b1;
                 w_tx_next = TX_START;
               end
      TX_START: begin
        w_tx_out = 1'b0;
        if (w_tx_bit_end) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        w_tx_out = r_tx_shift[0];
        if (w_tx_bit_end && r_tx_bidx == DataLast)
          w_tx_next = ParityEn ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        w_tx_out = r_tx_par;
        if (w_tx_bit_end) w_tx_next = TX_STOP;
      end
      TX_STOP: if (w_tx_bit_end && r_tx_bidx == StopLast) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_tx_state <= TX_IDLE;
    else         r_tx_state <= w_tx_next;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tx_tcnt  <= '0;
      r_tx_bidx  <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      if (r_tx_state == TX_IDLE || w_tx_bit_end) r_tx_tcnt <= '0;
      else if (w_tick)                           r_tx_tcnt <= r_tx_tcnt + 3'd1;
      if (w_pop) begin
        r_tx_shift <= w_rdata;
        r_tx_par   <= parity_bit(9'(w_rdata), ParityOdd);
        r_tx_bidx  <= '0;
      end else if (w_tx_bit_end) begin
        case (r_tx_state)
          TX_DATA: begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bidx  <= (r_tx_bidx == DataLast) ? 4'd0 : r_tx_bidx + 4'd1;
          end
          TX_STOP: r_tx_bidx <= r_tx_bidx + 4'd1;
          default: ;
        endcase
      end
    end
  end

  // Combinational from state so an asynchronous reset forces the line idle at once.
  assign tx_data_o = w_tx_out;

endmodule

// File: tb/tb_uart_echo_buffered.sv
// Directed bench for uart_echo_buffered (Prescale=1, 8-cycle bits, Depth=16).
module tb_uart_echo_buffered;

`ifdef UART_ECHO_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rx_data_i;
  logic       tx_data_o;
  logic       tx_hold_i;
  logic       clear_err_i;
  logic [4:0] fifo_count_o;
  logic       overflow_o;
  logic       frame_err_o;
  logic       parity_err_o;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  // Clock / reset
  always #5 clk_i = ~clk_i;

  uart_echo_buffered #(
    .DataWidth (8),
    .Prescale  (16'd1),
    .Depth     (16),
    .StopBits  (1),
    .ParityOdd (1'b0)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rx_data_i    (rx_data_i),
    .tx_data_o    (tx_data_o),
    .tx_hold_i    (tx_hold_i),
    .clear_err_i  (clear_err_i),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: every call starts and ends on a falling edge.
  task automatic drive_bit(input logic b);
    rx_data_i = b;
    repeat (8) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_ECHO_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b === 1'bx) rx_data_i = 1'b0;
`endif
    drive_bit(stop_b);
  endtask

  task automatic wait_tx_low(input int budget);
    int n;
    n = 0;
    while (tx_data_o !== 1'b0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  task automatic capture_frame(input string tag, input logic [7:0] d, input logic par_b);
    logic [10:0] exp_bits;
    logic [10:0] obs_bits;
    int          glitches;
    exp_bits      = '1;
    exp_bits[0]   = 1'b0;
    exp_bits[8:1] = d;
`ifdef UART_ECHO_PARITY_EN
    exp_bits[9]   = par_b;
`else
    if (par_b === 1'bx) exp_bits[9] = 1'b1;
`endif
    obs_bits = '1;
    wait_tx_low(300);
    check({tag, " start"}, 32'(tx_data_o), 32'h0);
    if (tx_data_o === 1'b0) begin
      glitches = 0;
      for (int k = 0; k < FrameBits * 8; k++) begin
        if (k % 8 == 4) obs_bits[k/8] = tx_data_o;
        if (tx_data_o !== exp_bits[k/8]) glitches++;
        @(negedge clk_i);
      end
      check({tag, " frame"}, 32'(obs_bits), 32'(exp_bits));
      check({tag, " stable"}, 32'(glitches), 32'h0);
    end
  endtask

  // Scoreboard: next echoed frame must match the head of exp_q.
  task automatic capture_next(input string tag);
    logic [7:0] d;
    check({tag, " queue"}, 32'(exp_q.size() > 0), 32'h1);
    if (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      capture_frame(tag, d, ^d);
    end
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_data_o !== 1'b1) lows++;
      @(negedge clk_i);
    end
    check(tag, 32'(lows), 32'h0);
  endtask

  initial begin
    reset_i     = 1'b1;
    rx_data_i   = 1'b1;
    tx_hold_i   = 1'b0;
    clear_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst tx",    32'(tx_data_o),    32'h1);
    check("rst count", 32'(fifo_count_o), 32'h0);
    check("rst ovf",   32'(overflow_o),   32'h0);
    check("rst ferr",  32'(frame_err_o),  32'h0);
    check("rst perr",  32'(parity_err_o), 32'h0);
    reset_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Reset asserted while the echo start bit is on the line
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_tx_low(50);
    check("mid start seen", 32'(tx_data_o), 32'h0);
    reset_i = 1'b1;
    #1;
    check("mid rst tx", 32'(tx_data_o), 32'h1);
    check("mid rst count", 32'(fifo_count_o), 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    quiet_check("mid rst quiet", 120);

    // Every byte value, one at a time
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1, ^(8'(v)));
      capture_next("echo");
    end

    // Fill under hold, overflow on the 17th byte, then drain in order
    tx_hold_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
      send_frame(8'(8'h10 + i), 1'b1, ^(8'(8'h10 + i)));
      if (i == 15) begin
        repeat (2) @(negedge clk_i);
        check("full count", 32'(fifo_count_o), 32'd16);
        check("full no ovf", 32'(overflow_o), 32'h0);
      end
    end
    repeat (3) @(negedge clk_i);
    check("ovf count", 32'(fifo_count_o), 32'd16);
    check("ovf flag",  32'(overflow_o),   32'h1);
    tx_hold_i = 1'b0;
    repeat (16) capture_next("drain");
    quiet_check("no 0x20", 200);
    check("drain count", 32'(fifo_count_o), 32'h0);
    check("ovf sticky",  32'(overflow_o),   32'h1);
    clear_err_i = 1'b1;
    @(negedge clk_i);
    clear_err_i = 1'b0;
    check("ovf cleared", 32'(overflow_o), 32'h0);

    // Framing error: stop bit low
    send_frame(8'h5A, 1'b0, ^(8'h5A));
    rx_data_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("ferr set",   32'(frame_err_o),  32'h1);
    check("ferr count", 32'(fifo_count_o), 32'h0);
    check("ferr ovf",   32'(overflow_o),   32'h0);
    quiet_check("ferr no echo", 120);
    clear_err_i = 1'b1;
    @(negedge clk_i);
    clear_err_i = 1'b0;
    check("ferr cleared", 32'(frame_err_o), 32'h0);

    // Clear coincides with the cycle a new framing error is flagged
    fork
      send_frame(8'h3C, 1'b0, ^(8'h3C));
      begin
        repeat (FrameBits * 8 - 1) @(negedge clk_i);
        clear_err_i = 1'b1;
        @(negedge clk_i);
        clear_err_i = 1'b0;
      end
    join
    rx_data_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("ferr beats clear", 32'(frame_err_o), 32'h1);
    clear_err_i = 1'b1;
    @(negedge clk_i);
    clear_err_i = 1'b0;
    check("ferr cleared 2", 32'(frame_err_o), 32'h0);

    // False start: 2-cycle low glitch
    rx_data_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rx_data_i = 1'b1;
    quiet_check("glitch quiet", 120);
    check("glitch count", 32'(fifo_count_o), 32'h0);
    check("glitch ferr",  32'(frame_err_o),  32'h0);
    check("glitch ovf",   32'(overflow_o),   32'h0);
    check("glitch perr",  32'(parity_err_o), 32'h0);

`ifdef UART_ECHO_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    capture_frame("par ok", 8'h07, 1'b1);
    check("par ok flag", 32'(parity_err_o), 32'h0);
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (3) @(negedge clk_i);
    check("par err flag",  32'(parity_err_o), 32'h1);
    check("par err count", 32'(fifo_count_o), 32'h0);
    quiet_check("par err no echo", 120);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
